// File: rtl/liveness_monitor.sv
// Liveness monitor: per-channel IDLE/WAIT/FAIL deadline tracking with sticky violation reporting.
// Define LIVENESS_WORST_WAIT_EN to track the worst satisfied request-response latency on worst_wait.
module liveness_monitor #(
    parameter int                NUM_CH     = 4,
    parameter int                MAX_WAIT   = 50,
    parameter int                CNT_W      = 6,
    parameter logic [NUM_CH-1:0] RECUR_MASK = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH-1:0]         grant,
    input  logic                      clear,
    output logic [NUM_CH-1:0]         pending,
    output logic [NUM_CH-1:0]         violation,
    output logic                      violation_pulse,
    output logic [$clog2(NUM_CH)-1:0] first_ch,
    output logic                      any_violation,
    output logic [CNT_W-1:0]          worst_wait
);

    localparam int             CH_W  = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] MAX_E = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] ONE_E = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, WAIT, FAIL} ch_state_t;

    logic [NUM_CH-1:0] miss;
    logic [CH_W-1:0]   miss_idx;

`ifdef LIVENESS_WORST_WAIT_EN
    logic [CNT_W-1:0] sat_e [NUM_CH];
    logic [CNT_W-1:0] sat_max;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam bit RECUR = RECUR_MASK[i];

        ch_state_t        state;
        logic [CNT_W-1:0] e;
        logic             pend_q;
        logic             viol_q;

        assign miss[i]      = (state == WAIT) && !grant[i] && (e == MAX_E);
        assign pending[i]   = pend_q;
        assign violation[i] = viol_q;

`ifdef LIVENESS_WORST_WAIT_EN
        assign sat_e[i] = (!RECUR && state == WAIT && grant[i]) ? e : '0;
`endif

        // NOTE: sequential state uses non-blocking assignments so every channel samples pre-edge values.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state  <= IDLE;
                e      <= '0;
                pend_q <= 1'b0;
                viol_q <= 1'b0;
            end else if (miss[i]) begin
                // A deadline miss beats a simultaneous clear; the counter is frozen at MAX_WAIT.
                state  <= FAIL;
                pend_q <= 1'b0;
                viol_q <= 1'b1;
            end else if (clear) begin
                viol_q <= 1'b0;
                if (RECUR) begin
                    state  <= WAIT;
                    e      <= ONE_E;
                    pend_q <= 1'b1;
                end else begin
                    state  <= IDLE;
                    e      <= '0;
                    pend_q <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (RECUR || req[i]) begin
                            state  <= WAIT;
                            e      <= ONE_E;
                            pend_q <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (grant[i]) begin
                            if (!RECUR && !req[i]) begin
                                state  <= IDLE;
                                e      <= '0;
                                pend_q <= 1'b0;
                            end else begin
                                e <= ONE_E;
                            end
                        end else begin
                            e <= e + ONE_E;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Lowest failing index wins when several channels miss in the same cycle.
    always_comb begin
        miss_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (miss[i]) miss_idx = CH_W'(i);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            violation_pulse <= 1'b0;
            first_ch        <= '0;
            any_violation   <= 1'b0;
        end else begin
            violation_pulse <= |miss;
            if (clear) begin
                any_violation <= |miss;
                first_ch      <= miss_idx;
            end else if (!any_violation && |miss) begin
                any_violation <= 1'b1;
                first_ch      <= miss_idx;
            end
        end
    end

`ifdef LIVENESS_WORST_WAIT_EN
    always_comb begin
        sat_max = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sat_e[i] > sat_max) sat_max = sat_e[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            worst_wait <= '0;
        end else if (clear) begin
            worst_wait <= '0;
        end else if (sat_max > worst_wait) begin
            worst_wait <= sat_max;
        end
    end
`else
    assign worst_wait = '0;
`endif

endmodule

// File: tb/tb_liveness_monitor.sv
// Directed bench for liveness_monitor (NUM_CH=4, MAX_WAIT=50, RECUR_MASK=4'b1100).
module tb_liveness_monitor;

    localparam int NUM_CH   = 4;
    localparam int MAX_WAIT = 50;
    localparam int CNT_W    = 6;

`ifdef LIVENESS_WORST_WAIT_EN
    localparam logic [CNT_W-1:0] WW_AFTER_7  = 6'd7;
    localparam logic [CNT_W-1:0] WW_AFTER_ALL = 6'd33;
`else
    localparam logic [CNT_W-1:0] WW_AFTER_7  = 6'd0;
    localparam logic [CNT_W-1:0] WW_AFTER_ALL = 6'd0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic              clear;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] violation;
    logic              violation_pulse;
    logic [1:0]        first_ch;
    logic              any_violation;
    logic [CNT_W-1:0]  worst_wait;

    int vectors    = 0;
    int miscompares = 0;

    liveness_monitor #(
        .NUM_CH    (NUM_CH),
        .MAX_WAIT  (MAX_WAIT),
        .CNT_W     (CNT_W),
        .RECUR_MASK(4'b1100)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .grant          (grant),
        .clear          (clear),
        .pending        (pending),
        .violation      (violation),
        .violation_pulse(violation_pulse),
        .first_ch       (first_ch),
        .any_violation  (any_violation),
        .worst_wait     (worst_wait)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        grant = 4'b1100;
        clear = 1'b0;
        #1;
        check("reset_outputs", {pending, violation, violation_pulse, first_ch, any_violation, worst_wait},
              '0);
        tick(1);
        reset = 1'b0;
        tick(1);
        check("recur_enter_wait", pending, 4'b1100);

        // Reset asserted asynchronously in the middle of a wait.
        req[0] = 1'b1;
        tick(1);
        req[0] = 1'b0;
        check("ch0_armed", pending, 4'b1101);
        tick(19);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", {pending, violation, violation_pulse, first_ch, any_violation}, '0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(100);
        check("post_reset_no_violation", violation, 4'b0000);
        check("post_reset_pending", pending, 4'b1100);

        // Grant exactly at e=MAX_WAIT is on time.
        req[0] = 1'b1;
        tick(1);
        req[0] = 1'b0;
        tick(49);
        check("boundary_still_waiting", {pending, violation}, {4'b1101, 4'b0000});
        grant[0] = 1'b1;
        tick(1);
        grant[0] = 1'b0;
        check("boundary_grant_ok", {pending, violation, violation_pulse}, {4'b1100, 4'b0000, 1'b0});

        // One cycle later is a miss.
        req[0] = 1'b1;
        tick(1);
        req[0] = 1'b0;
        tick(49);
        check("late_pre_edge", violation, 4'b0000);
        tick(1);
        check("late_violation", {violation, violation_pulse, any_violation, first_ch, pending},
              {4'b0001, 1'b1, 1'b1, 2'd0, 4'b1100});
        grant[0] = 1'b1;
        tick(1);
        grant[0] = 1'b0;
        check("pulse_one_cycle_sticky", {violation_pulse, violation}, {1'b0, 4'b0001});

        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_state", {violation, any_violation, first_ch, pending}, {4'b0000, 1'b0, 2'd0, 4'b1100});

        // A grant in the same cycle as the request does not satisfy it.
        req[0]   = 1'b1;
        grant[0] = 1'b1;
        tick(1);
        req[0]   = 1'b0;
        grant[0] = 1'b0;
        check("same_cycle_idle_grant", pending, 4'b1101);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;

        // Grant together with a new request re-arms the deadline.
        req[1] = 1'b1;
        tick(1);
        req[1] = 1'b0;
        tick(24);
        req[1]   = 1'b1;
        grant[1] = 1'b1;
        tick(1);
        req[1]   = 1'b0;
        grant[1] = 1'b0;
        check("rearm_pending", pending, 4'b1110);
        tick(49);
        check("rearm_pre_edge", violation, 4'b0000);
        tick(1);
        check("rearm_violation", {violation, violation_pulse, first_ch, any_violation},
              {4'b0010, 1'b1, 2'd1, 1'b1});
        clear = 1'b1;
        tick(1);
        clear = 1'b0;

        // Recurrence channel granted every 50 cycles never fails.
        grant[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(49);
            grant[2] = 1'b1;
            tick(1);
            grant[2] = 1'b0;
        end
        grant[2] = 1'b1;
        check("recur_period_ok", {violation, pending}, {4'b0000, 4'b1100});

        // Recurrence channel starved from reset release fails on cycle 51.
        grant[3] = 1'b0;
        do_reset();
        tick(50);
        check("recur_starve_pre", violation, 4'b0000);
        tick(1);
        check("recur_starve_fail", {violation, violation_pulse, first_ch, any_violation},
              {4'b1000, 1'b1, 2'd3, 1'b1});

        // Two channels miss together, then a miss coincides with clear.
        grant = 4'b1000;
        req   = 4'b0001;
        do_reset();
        tick(1);
        req = '0;
        tick(49);
        tick(1);
        check("dual_fail", {violation, violation_pulse, first_ch, any_violation},
              {4'b0101, 1'b1, 2'd0, 1'b1});
        tick(1);
        check("dual_single_pulse", violation_pulse, 1'b0);
        grant[3] = 1'b0;
        tick(49);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        grant = 4'b1100;
        check("clear_vs_miss", {violation, any_violation, first_ch, violation_pulse, pending},
              {4'b1000, 1'b1, 2'd3, 1'b1, 4'b0100});

        // Worst satisfied latency over grants at 7, 33 and 12.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_all", {violation, any_violation}, {4'b0000, 1'b0});
        req[0] = 1'b1;
        tick(1);
        req[0] = 1'b0;
        tick(6);
        grant[0] = 1'b1;
        tick(1);
        grant[0] = 1'b0;
        check("worst_after_7", worst_wait, WW_AFTER_7);
        req[1] = 1'b1;
        tick(1);
        req[1] = 1'b0;
        tick(32);
        grant[1] = 1'b1;
        tick(1);
        grant[1] = 1'b0;
        req[0] = 1'b1;
        tick(1);
        req[0] = 1'b0;
        tick(11);
        grant[0] = 1'b1;
        tick(1);
        grant[0] = 1'b0;
        check("worst_after_all", worst_wait, WW_AFTER_ALL);
        check("worst_seq_pending", {pending, violation}, {4'b1100, 4'b0000});
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("worst_cleared", worst_wait, 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/liveness_monitor.md
Name: liveness_monitor

Overview:
- Synthesizable, parametrised liveness monitor for the intersection controller.
- Watches NUM_CH channels, each a request/grant pair (e.g. pedestrian_button/pedestrian_green, turn_sensor/turn_green) or a recurrence-only grant (e.g. up_green, down_green).
- Flags any channel whose grant does not arrive within MAX_WAIT cycles.
- Runs in silicon and in simulation and feeds a fault/fallback path. Replaces bind-only assertion checking.

Parameters:
- NUM_CH, 4: number of monitored channels, ≥2.
- MAX_WAIT, 50: deadline in cycles, ≥1.
- CNT_W, 6: elapsed-counter width; must satisfy 2**CNT_W > MAX_WAIT.
- RECUR_MASK, 0 (NUM_CH bits): bit i=1 puts channel i in recurrence mode; 0 puts it in request-response mode.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_CH  per-channel request level, sampled each cycle; ignored for recurrence channels.
- grant  in  NUM_CH  per-channel grant (green) level.
- clear  in  1  synchronous clear of all sticky state.
- pending  out  NUM_CH  channel is in WAIT.
- violation  out  NUM_CH  sticky per-channel violation flag.
- violation_pulse  out  1  high one cycle when any channel enters FAIL.
- first_ch  out  $clog2(NUM_CH)  lowest channel index of the first violation event since reset/clear.
- any_violation  out  1  OR of violation; qualifies first_ch.
- worst_wait  out  CNT_W  see Optional Feature.

Behaviour:
- Reset (async assert, sync use after release) sets every output to 0, all channels to IDLE, all counters to 0.
- Each channel has a 3-state FSM (IDLE, WAIT, FAIL) and an elapsed counter e.

Request-response channel (RECUR_MASK[i]=0):
- IDLE, req=1 → WAIT with e=1 next cycle. A grant in the same cycle as req does not satisfy that req.
- WAIT, each cycle:
  - grant=1 and req=0 → IDLE, e=0.
  - grant=1 and req=1 → stay in WAIT, e=1 (re-armed for the new request).
  - grant=0 and e<MAX_WAIT → e+1.
  - grant=0 and e==MAX_WAIT → FAIL.
- A grant at e∈[1,MAX_WAIT] satisfies the request; a grant at e=MAX_WAIT is still on time.
- Further req pulses while in WAIT do not restart e. The oldest outstanding request governs the deadline.

Recurrence channel (RECUR_MASK[i]=1):
- Never uses IDLE. Enters WAIT with e=1 on the first cycle after reset release.
- grant=1 → e=1. Otherwise e+1. grant=0 at e==MAX_WAIT → FAIL.
- Consequence: MAX_WAIT consecutive grant-free cycles is a violation.
- pending is always 1 outside FAIL.

FAIL (both modes):
- violation[i]=1, counter held, pending[i]=0.
- Channel stays in FAIL until clear.

Violation reporting:
- violation_pulse is registered: it is high the cycle after the deadline miss, the same cycle violation[i] first reads 1.
- Several channels failing in the same cycle produce one pulse. first_ch = lowest index among them.
- first_ch and any_violation latch only on the first event. Later events leave first_ch unchanged.

Clear:
- clear=1 returns all non-failing channels to the post-reset state: IDLE, or WAIT with e=1 for recurrence channels.
- Clears violation, any_violation and first_ch.
- A deadline miss in the same cycle as clear wins for that channel: it enters FAIL, its flag stays set, and violation_pulse fires.

Counter rules:
- e never wraps; it saturates at MAX_WAIT by construction.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: LIVENESS_WORST_WAIT_EN.
- Defined: worst_wait holds the maximum e at which any request-response grant satisfied an outstanding request. Updated when a larger e occurs; reset/clear sets it to 0. Recurrence-channel gaps are not included.
- Not defined: worst_wait is tied to 0 and no tracking logic is instantiated.

Test Plan (NUM_CH=4, MAX_WAIT=50, RECUR_MASK=4'b1100):
- Reset mid-WAIT: req[0] pulse, then reset asserted asynchronously at e=20 → all outputs 0 immediately. After release, no violation for ch0 even with no grant for 100 cycles.
- Deadline boundary: req[0] at cycle 10, grant[0] at cycle 60 → no violation, pending[0] drops at cycle 61. Repeat with grant at cycle 61 → violation[0]=1 and violation_pulse at cycle 61, first_ch=0.
- Same-cycle grant and req: req[1] at cycle 5; then req[1]=1 and grant[1]=1 together at cycle 30 with no further grant → ch1 stays pending, violation at cycle 81.
- Recurrence: grant[2] every 50 cycles → never fails. grant[3] held 0 after reset release → violation[3] on cycle 51 after release.
- Simultaneous failures and clear: ch0 and ch2 both miss in the same cycle → one violation_pulse, first_ch=0. Assert clear while ch3 misses that cycle → violation=4'b1000, any_violation=1, first_ch=3.
- With LIVENESS_WORST_WAIT_EN defined: grant latencies 7, 33, 12 on ch0/ch1 → worst_wait=33. After clear, worst_wait=0.
